// File: rtl/mem_access_unit_if.sv
// Request/response handshake between the MEM pipeline stage and mem_access_unit.
// master = pipeline side, slave = mem_access_unit.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_byte;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Initiator side of the main memory port: word/byte loads and stores, byte store as RMW.
// Optional MEM_BUS_ASSERT_EN: raise mem_assert alongside rsp_valid for word loads.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_unit_if.slave      pipe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_load,
  output logic                  mem_assert,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StRdata, StMerge, StResp} state_e;

  state_e                state_q;
  logic                  we_q;
  logic                  byte_q;
  logic [7:0]            wbyte_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rsp_valid_q;

  assign pipe.req_ready = (state_q == StIdle);
  assign pipe.rsp_valid = rsp_valid_q;
  assign pipe.rsp_rdata = rdata_q;

  // mem_addr doubles as the latched request address; it holds from acceptance to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      wbyte_q     <= 8'h00;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_load    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pipe.req_valid) begin
            we_q     <= pipe.req_we;
            byte_q   <= pipe.req_byte;
            wbyte_q  <= pipe.req_wdata[7:0];
            mem_addr <= pipe.req_addr;
            if (pipe.req_we && !pipe.req_byte) begin
              mem_wdata <= pipe.req_wdata;
              mem_load  <= 1'b1;
              state_q   <= StWrite;
            end else begin
              state_q   <= StRead;
            end
          end
        end
        StWrite: begin
          mem_load    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StRead: begin
          state_q <= StRdata;
        end
        StRdata: begin
          if (we_q) begin
            // Big-endian: new byte goes to M[a], M[a+1] is written back unchanged.
            mem_wdata <= {wbyte_q, mem_rdata[7:0]};
            mem_load  <= 1'b1;
            state_q   <= StMerge;
          end else begin
            rdata_q     <= byte_q ? {8'h00, mem_rdata[15:8]} : mem_rdata;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StMerge: begin
          mem_load    <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          mem_load <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

`ifdef MEM_BUS_ASSERT_EN
  // Loads always pass RDATA -> RESP, so this lands exactly on the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_assert <= 1'b0;
    end else begin
      mem_assert <= (state_q == StRdata) && !we_q && !byte_q;
    end
  end
`else
  assign mem_assert = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand-written corner sequences,
// and randomized requests checked against a byte-array reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_load;
  logic        mem_assert;

  mem_access_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  mem_access_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pipe      (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_load  (mem_load),
    .mem_assert(mem_assert),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

`ifdef MEM_BUS_ASSERT_EN
  localparam bit AssertEn = 1'b1;
`else
  localparam bit AssertEn = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  int rsp_cnt = 0;
  int assert_cnt = 0;
  int assert_bad = 0;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] ref_rdata;
  logic [15:0] mem_addr_p1;

  assign mem_addr_p1 = mem_addr + 16'd1;

  // Memory block: synchronous write, read data valid the cycle after the address is sampled.
  always @(posedge clk) begin
    if (mem_load) begin
      ram[mem_addr]    = mem_wdata[15:8];
      ram[mem_addr_p1] = mem_wdata[7:0];
    end else begin
      mem_rdata <= {ram[mem_addr], ram[mem_addr_p1]};
    end
  end

  always @(posedge clk) begin
    if (mem_load) load_cnt++;
    if (bus.rsp_valid) rsp_cnt++;
    if (mem_assert) assert_cnt++;
    if (mem_assert && !bus.rsp_valid) assert_bad++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: byte array plus last load result.
  task automatic model(input logic we, input logic byt, input logic [15:0] addr,
                       input logic [15:0] wdata);
    logic [15:0] a1;
    a1 = addr + 16'd1;
    if (we && !byt) begin
      ref_mem[addr] = wdata[15:8];
      ref_mem[a1]   = wdata[7:0];
    end else if (we) begin
      ref_mem[addr] = wdata[7:0];
    end else if (byt) begin
      ref_rdata = {8'h00, ref_mem[addr]};
    end else begin
      ref_rdata = {ref_mem[addr], ref_mem[a1]};
    end
  endtask

  function automatic int lat_of(input logic we, input logic byt);
    if (!we) return 3;
    return byt ? 4 : 2;
  endfunction

  task automatic check_mem(input string tag, input logic [15:0] addr);
    logic [15:0] a1;
    a1 = addr + 16'd1;
    check($sformatf("%s_m0", tag), {24'h0, ram[addr]}, {24'h0, ref_mem[addr]});
    check($sformatf("%s_m1", tag), {24'h0, ram[a1]}, {24'h0, ref_mem[a1]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_ready", tag), {31'h0, bus.req_ready}, 1);
    check($sformatf("%s_rsp_valid", tag), {31'h0, bus.rsp_valid}, 0);
    check($sformatf("%s_rsp_rdata", tag), {16'h0, bus.rsp_rdata}, 0);
    check($sformatf("%s_mem_load", tag), {31'h0, mem_load}, 0);
    check($sformatf("%s_mem_assert", tag), {31'h0, mem_assert}, 0);
    check($sformatf("%s_mem_addr", tag), {16'h0, mem_addr}, 0);
    check($sformatf("%s_mem_wdata", tag), {16'h0, mem_wdata}, 0);
  endtask

  // Latency = number of posedges from acceptance to the edge that samples rsp_valid high.
  task automatic run_req(input string tag, input logic we, input logic byt,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rd, input int exp_lat, input int exp_loads);
    int          l0, r0, a0, lat;
    logic        acc, asrt, exp_a;
    logic [15:0] rd;
    exp_a = AssertEn && !we && !byt;
    acc = 1'b0; asrt = 1'b0; rd = '0;
    l0 = 0; r0 = 0; a0 = 0; lat = -1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_byte  = byt;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 20; i++) begin
      if (!acc) begin
        if (bus.req_ready) begin
          acc = 1'b1;
          l0 = load_cnt; r0 = rsp_cnt; a0 = assert_cnt;
          @(posedge clk);
          #1;
          bus.req_valid = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
    end
    bus.req_valid = 1'b0;
    check($sformatf("%s_accept", tag), {31'h0, acc}, 1);
    if (acc) begin
      for (int n = 1; n <= 20; n++) begin
        if (lat < 0) begin
          @(negedge clk);
          if (bus.rsp_valid) begin
            lat  = n;
            rd   = bus.rsp_rdata;
            asrt = mem_assert;
          end
        end
      end
      @(negedge clk);
      check($sformatf("%s_rsp_width", tag), {31'h0, bus.rsp_valid}, 0);
      check($sformatf("%s_latency", tag), lat, exp_lat);
      check($sformatf("%s_rdata", tag), {16'h0, rd}, {16'h0, exp_rd});
      check($sformatf("%s_loads", tag), load_cnt - l0, exp_loads);
      check($sformatf("%s_rsp_count", tag), rsp_cnt - r0, 1);
      check($sformatf("%s_assert_at_rsp", tag), {31'h0, asrt}, {31'h0, exp_a});
      check($sformatf("%s_assert_count", tag), assert_cnt - a0, {31'h0, exp_a});
    end
  endtask

  typedef struct {
    logic        we;
    logic        byt;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
    int          exp_loads;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int          first_ready, got, l0, r0;
    int          rsp_n [2];
    logic [15:0] rsp_d [2];
    logic [15:0] exp0, exp1;
    logic        we, byt;
    logic [15:0] addr, wdata;

    tbl[0] = '{1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, 2, 1};
    tbl[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 3, 0};
    tbl[2] = '{1'b1, 1'b1, 16'h0010, 16'h55AB, 16'h1234, 4, 1};
    tbl[3] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hAB34, 3, 0};
    tbl[4] = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0034, 3, 0};
    tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 16'hBEEF, 16'h0034, 2, 1};
    tbl[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 3, 0};

    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ref_rdata = 16'h0000;

    // Reset with a store request pending: nothing may be accepted.
    rst_n         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_byte  = 1'b0;
    bus.req_addr  = 16'h0010;
    bus.req_wdata = 16'hDEAD;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    bus.req_valid = 1'b0;
    check("reset_no_store", load_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready_after", {31'h0, bus.req_ready}, 1);
    check_mem("reset_mem", 16'h0010);

    for (int i = 0; i < 7; i++) begin
      model(tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata);
      run_req($sformatf("tbl%0d", i), tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_rd, tbl[i].exp_lat, tbl[i].exp_loads);
      if (tbl[i].we) check_mem($sformatf("tbl%0d", i), tbl[i].addr);
    end

    // Back-to-back: byte store then word load with req_valid held high throughout.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_byte  = 1'b1;
    bus.req_addr  = 16'h0020;
    bus.req_wdata = 16'h00CD;
    check("b2b_ready0", {31'h0, bus.req_ready}, 1);
    model(1'b1, 1'b1, 16'h0020, 16'h00CD);
    exp0 = ref_rdata;
    @(posedge clk);
    #1;
    bus.req_we   = 1'b0;
    bus.req_byte = 1'b0;
    model(1'b0, 1'b0, 16'h0020, 16'h0000);
    exp1 = ref_rdata;
    first_ready = -1; got = 0;
    rsp_n[0] = -1; rsp_n[1] = -1; rsp_d[0] = '0; rsp_d[1] = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (first_ready > 0 && n == first_ready + 1) bus.req_valid = 1'b0;
      if (first_ready < 0 && bus.req_ready) first_ready = n;
      if (bus.rsp_valid && got < 2) begin
        rsp_n[got] = n;
        rsp_d[got] = bus.rsp_rdata;
        got++;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_ready_return", first_ready, 5);
    check("b2b_rsp_count", got, 2);
    check("b2b_rsp0_cycle", rsp_n[0], 4);
    check("b2b_rsp1_cycle", rsp_n[1], 8);
    check("b2b_rsp0_rdata", {16'h0, rsp_d[0]}, {16'h0, exp0});
    check("b2b_rsp1_rdata", {16'h0, rsp_d[1]}, {16'h0, exp1});
    check_mem("b2b", 16'h0020);

    // Reset while a byte store sits in RDATA: memory must be left untouched.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_byte  = 1'b1;
    bus.req_addr  = 16'h0010;
    bus.req_wdata = 16'h00FF;
    check("rstmid_ready", {31'h0, bus.req_ready}, 1);
    l0 = load_cnt; r0 = rsp_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ref_rdata = 16'h0000;
    check("rstmid_no_store", load_cnt - l0, 0);
    check("rstmid_no_rsp", rsp_cnt - r0, 0);
    check_mem("rstmid", 16'h0010);

    for (int i = 0; i < 80; i++) begin
      we    = 1'($urandom);
      byt   = 1'($urandom);
      addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1))
                                          : 16'h0100 + 16'($urandom_range(0, 11));
      wdata = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(we, byt, addr, wdata);
      run_req($sformatf("rnd%0d", i), we, byt, addr, wdata, ref_rdata, lat_of(we, byt),
              we ? 1 : 0);
      if (we) check_mem($sformatf("rnd%0d", i), addr);
    end

    check("assert_outside_rsp", assert_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the main memory port. Accepts load/store requests from the pipeline's memory stage over a valid/ready handshake and sequences the memory's Addr/MainBusIn/load/mem_assert signals. Captures read data from MemDataOut. Adds byte-granular loads (zero-extended) and byte stores, done as read-modify-write. Sits between the MEM pipeline stage and the memory block.

Parameters:
ADDR_WIDTH, 16, byte address width; must match the memory.
DATA_WIDTH, 16, word width; only 16 is supported (the memory splits words into two bytes).

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present; requester holds all req_* stable until accepted
req_ready  output  1  unit idle; request accepted on a posedge where req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_byte  input  1  1 = byte access, 0 = word access
req_addr  input  ADDR_WIDTH  byte address; word = {M[a], M[a+1]}, big-endian
req_wdata  input  DATA_WIDTH  store data; byte store uses [7:0]
rsp_valid  output  1  one-cycle completion pulse; no back-pressure
rsp_rdata  output  DATA_WIDTH  load result, registered
mem_addr  output  ADDR_WIDTH  to memory Addr
mem_wdata  output  DATA_WIDTH  to memory MainBusIn
mem_load  output  1  to memory load (write enable)
mem_assert  output  1  to memory mem_assert
mem_rdata  input  DATA_WIDTH  from memory MemDataOut; valid the cycle after mem_addr is sampled with mem_load=0

Behaviour:
- States: IDLE, WRITE, READ, RDATA, MERGE, RESP. Reset state is IDLE.
- Reset values: all latched request registers = 0, rsp_rdata = 0, rsp_valid = 0, mem_load = 0, mem_assert = 0, mem_addr = 0, mem_wdata = 0.
- req_ready = (state == IDLE). This includes the time rst_n is low, but nothing is accepted while rst_n is low.
- IDLE: on acceptance, latch addr/wdata/we/byte. Word store goes to WRITE. Every other request goes to READ.
- WRITE: mem_addr = addr_q, mem_wdata = wdata_q, mem_load = 1. Next state RESP.
- READ: mem_addr = addr_q, mem_load = 0. Next state RDATA.
- RDATA: mem_rdata holds {M[a], M[a+1]}.
  - Word load: rsp_rdata <= mem_rdata, next state RESP.
  - Byte load: rsp_rdata <= {8'h00, mem_rdata[15:8]}, next state RESP.
  - Byte store: latch merge = {wdata_q[7:0], mem_rdata[7:0]}, next state MERGE.
- MERGE: mem_addr = addr_q, mem_wdata = merge, mem_load = 1. Next state RESP.
- RESP: rsp_valid = 1 for exactly one cycle. mem_addr stays addr_q, mem_load = 0. Next state IDLE.
- Latency from the acceptance edge to rsp_valid high: word store 2 cycles, load 3 cycles, byte store 4 cycles.
- Stores leave rsp_rdata unchanged.
- mem_load is high only in WRITE and MERGE, and for exactly one cycle per store.
- Address wrap: no special handling. A word at 0xFFFF uses M[0xFFFF] and M[0x0000] through the memory's own truncation of Addr+1.
- Requests presented while busy are ignored (req_ready = 0). The requester keeps req_valid high.
- Reset mid-operation: return to IDLE immediately and drop mem_load at once. No rsp_valid is issued for the lost request. A byte store reset in READ or RDATA must leave memory unmodified.
- mem_assert = 0 always, unless the optional feature is compiled in.

Optional Feature:
MEM_BUS_ASSERT_EN
- Defined: for word loads only, mem_assert = 1 in RESP. The memory then drives the same word onto the main bus in the same cycle as rsp_valid; mem_addr is still addr_q, so memory dout is still the loaded word. mem_assert is 0 in all other states and for all other request types.
- Undefined: mem_assert is tied to 0.

Test Plan:
- Word store 0x1234 @0x0010, then word load @0x0010 -> mem_load one cycle; M[0x10] = 0x12, M[0x11] = 0x34; rsp_rdata = 0x1234; rsp_valid 2 cycles after the store is accepted and 3 cycles after the load is accepted.
- Byte store req_wdata = 0x55AB @0x0010 after the previous case, then word load @0x0010 -> rsp_rdata = 0xAB34; rsp_valid 4 cycles after acceptance; exactly one mem_load pulse.
- Byte load @0x0011 holding 0x34 -> rsp_rdata = 0x0034.
- Word store 0xBEEF @0xFFFF -> M[0xFFFF] = 0xBE, M[0x0000] = 0xEF; word load @0xFFFF returns 0xBEEF.
- req_valid held high with a byte store followed by a word load -> req_ready low for 4 cycles, then high one cycle after RESP; second request accepted; responses in order.
- Byte store 0x00FF @0x0010, rst_n low during RDATA -> no mem_load pulse, no rsp_valid, M[0x10..0x11] unchanged, all outputs at reset values; with MEM_BUS_ASSERT_EN defined, a word load shows mem_assert high coincident with rsp_valid.
